decoder_scan_ctrl: RTL and testbench
====================================

# decoder_scan_ctrl

Synchronous scan sequencer that drives the select and enable pins of the 74138 3-to-8 decoder directly downstream. It steps through decoder outputs 0..7 with a programmable dwell time, skips masked channels, and runs either one sweep or continuously. Typical use is LED/display multiplexing and chip-select strobing.

## Interface
- DWELL_W, 8: width of the dwell count; each channel is held for dwell_i+1 cycles.

- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  begin a scan; honoured only in IDLE.
- stop_i  in  1  abort the scan; returns to IDLE.
- mode_i  in  1  0 = continuous, 1 = single sweep; latched on an accepted start.
- dwell_i  in  DWELL_W  dwell minus one; latched on an accepted start.
- skip_mask_i  in  8  bit k=1 skips channel k; sampled live at every channel selection.
- select_a_o / select_b_o / select_c_o  out  1 each  channel index bits 0/1/2, to the 74138 A/B/C.
- g1_en_o  out  1  to 74138 G1 (active-high).
- g2a_en_n_o, g2b_en_n_o  out  1 each  to 74138 G2A/G2B (active-low).
- busy_o  out  1  scan in progress.
- wrap_o  out  1  one-cycle pulse on a continuous-mode wrap.
- done_o  out  1  one-cycle pulse at the natural end of a single sweep.

## Operation
- All outputs are registered. Reset values: selects 0, g1_en_o 0, g2a/g2b_en_n_o 1, busy_o 0, wrap_o 0, done_o 0, state IDLE, dwell counter 0.
- Enabled means g1=1 and g2a_n=g2b_n=0. Disabled means g1=0 and g2a_n=g2b_n=1. Outputs are enabled only in ACTIVE.
- States:
  - IDLE: decoder disabled. Selects hold their last value.
  - ACTIVE: selected channel is driven and the dwell counter counts.
  - GUARD: exists only when SCAN_GUARD_EN is defined.
- IDLE→ACTIVE on start_i=1 && stop_i=0 && skip_mask_i!=8'hFF.
  - Channel becomes the lowest unmasked index.
  - Dwell counter loads 0; busy_o=1.
  - A start with mask 8'hFF is ignored: no busy, no pulses.
- ACTIVE: counter increments each cycle. When it equals the latched dwell, the block advances.
  - The next channel is the lowest unmasked index strictly above the current one.
  - If there is none, behaviour depends on mode_i:
    - Single sweep: go to IDLE and pulse done_o.
    - Continuous: wrap to the lowest unmasked index and pulse wrap_o.
  - If the mask is all ones at an advance: go to IDLE, pulse done_o in both modes.
- stop_i=1 in ACTIVE/GUARD: IDLE on the next edge, decoder disabled, busy_o=0, no done_o pulse.
- start_i and stop_i in the same cycle: stop wins.
- start_i while busy: ignored. Dwell and mode are not re-latched.
- Counter arithmetic is DWELL_W bits unsigned. dwell_i=0 gives one cycle per channel.
- rst_i mid-scan forces the reset values immediately (asynchronously).

## Timing
- Start accepted at edge N: selects and enables are valid after edge N, and busy_o=1 after edge N.
- Each channel is enabled for exactly dwell+1 cycles.
- Without guard, the select change and the next channel enable happen on the same edge (back-to-back).
- done_o and wrap_o are high for exactly one cycle:
  - done_o on the edge that disables the outputs.
  - wrap_o on the edge that presents the wrapped channel (or enters GUARD before it).
- Stop latency: 1 cycle.

## Configuration
- SCAN_GUARD_EN defined:
  - Every channel advance, including wraps, passes through one GUARD cycle.
  - In GUARD: selects are already updated to the new channel, the decoder is disabled, busy_o=1.
  - The next cycle is ACTIVE on that channel.
  - A single-sweep end goes straight to IDLE with no guard.
- SCAN_GUARD_EN undefined: the GUARD state is absent, and advances are back-to-back as above.

## Structure
- Package decoder_scan_pkg holds:
  - NUM_CH=8 and CH_W=3.
  - typedef enum scan_state_e {SCAN_IDLE, SCAN_ACTIVE, SCAN_GUARD}.
- Sub-module scan_next_ch: a combinational search with inputs current index, mask and a "from bottom" flag.
  - Outputs: next index, found, wrapped.
  - It is used for both the start selection and every advance.

## Test plan
- Reset mid-scan: assert rst_i while channel 5 is active → all outputs at reset values immediately, busy_o=0.
- Single sweep, mask 8'h00, dwell_i=2:
  - Channels 0..7 each held 3 cycles, decoder enabled 24 cycles total.
  - done_o pulses once; busy_o then 0.
- Continuous, mask 8'b1010_0101, dwell_i=0:
  - Sequence 1,3,4,6,1,3…
  - wrap_o pulses together with each return to 1.
- Start and stop in the same cycle → remains IDLE.
  - Stop during channel 2 → next cycle disabled, no done_o.
- Start with mask 8'hFF → ignored.
  - Mask set to 8'hFF during a continuous scan → IDLE with a done_o pulse at the next advance.
- With SCAN_GUARD_EN, dwell_i=1, mask 8'h00:
  - Each channel gives 2 enabled cycles then 1 disabled cycle with the next select already present.
  - No guard cycle after channel 7 in single-sweep mode.

Source files
------------

// File: rtl/decoder_scan_pkg.sv
// Shared constants and state encoding for the 74138 scan sequencer.
package decoder_scan_pkg;
  localparam int NUM_CH = 8;
  localparam int CH_W   = 3;

  typedef enum logic [1:0] {
    SCAN_IDLE,
    SCAN_ACTIVE,
    SCAN_GUARD
  } scan_state_e;
endpackage

// File: rtl/scan_next_ch.sv
// Combinational channel search: lowest unmasked index, either from the bottom
// or strictly above cur_i with wrap-around to the bottom when nothing is above.
module scan_next_ch
  import decoder_scan_pkg::*;
(
  input  logic [CH_W-1:0]   cur_i,
  input  logic [NUM_CH-1:0] mask_i,
  input  logic              from_bottom_i,
  output logic [CH_W-1:0]   nxt_o,
  output logic              found_o,
  output logic              wrapped_o
);
  logic [CH_W-1:0] low_idx, up_idx;
  logic            low_found, up_found;

  // Descending scan so the last hit is the lowest qualifying index.
  always_comb begin
    low_idx   = '0;
    low_found = 1'b0;
    up_idx    = '0;
    up_found  = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (!mask_i[k]) begin
        low_idx   = CH_W'(k);
        low_found = 1'b1;
        if (k > int'(cur_i)) begin
          up_idx   = CH_W'(k);
          up_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    if (from_bottom_i || !up_found) begin
      nxt_o     = low_idx;
      found_o   = low_found;
      wrapped_o = !from_bottom_i && low_found;
    end else begin
      nxt_o     = up_idx;
      found_o   = 1'b1;
      wrapped_o = 1'b0;
    end
  end
endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scan sequencer driving 74138 select/enable pins with programmable dwell.
// Optional SCAN_GUARD_EN inserts one disabled guard cycle on every channel advance.
module decoder_scan_ctrl
  import decoder_scan_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               mode_i,
  input  logic [DWELL_W-1:0] dwell_i,
  input  logic [NUM_CH-1:0]  skip_mask_i,
  output logic               select_a_o,
  output logic               select_b_o,
  output logic               select_c_o,
  output logic               g1_en_o,
  output logic               g2a_en_n_o,
  output logic               g2b_en_n_o,
  output logic               busy_o,
  output logic               wrap_o,
  output logic               done_o
);
  scan_state_e        state_q;
  logic [CH_W-1:0]    ch_q;
  logic [DWELL_W-1:0] cnt_q, dwell_q;
  logic               mode_q, g1_q, g2n_q, busy_q, wrap_q, done_q;

  logic [CH_W-1:0] nxt_ch;
  logic            nxt_found, nxt_wrapped;

  // One search serves both start (from bottom) and advance (above current).
  scan_next_ch u_next (
    .cur_i        (ch_q),
    .mask_i       (skip_mask_i),
    .from_bottom_i(state_q == SCAN_IDLE),
    .nxt_o        (nxt_ch),
    .found_o      (nxt_found),
    .wrapped_o    (nxt_wrapped)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= SCAN_IDLE;
      ch_q    <= '0;
      cnt_q   <= '0;
      dwell_q <= '0;
      mode_q  <= 1'b0;
      g1_q    <= 1'b0;
      g2n_q   <= 1'b1;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        SCAN_IDLE: begin
          if (start_i && !stop_i && nxt_found) begin
            state_q <= SCAN_ACTIVE;
            ch_q    <= nxt_ch;
            cnt_q   <= '0;
            dwell_q <= dwell_i;
            mode_q  <= mode_i;
            g1_q    <= 1'b1;
            g2n_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        SCAN_ACTIVE: begin
          if (stop_i) begin
            state_q <= SCAN_IDLE;
            g1_q    <= 1'b0;
            g2n_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else if (cnt_q == dwell_q) begin
            // Single sweep ends on wrap; an all-masked advance ends either mode.
            if (!nxt_found || (nxt_wrapped && mode_q)) begin
              state_q <= SCAN_IDLE;
              g1_q    <= 1'b0;
              g2n_q   <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              ch_q   <= nxt_ch;
              cnt_q  <= '0;
              wrap_q <= nxt_wrapped;
`ifdef SCAN_GUARD_EN
              state_q <= SCAN_GUARD;
              g1_q    <= 1'b0;
              g2n_q   <= 1'b1;
`endif
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`ifdef SCAN_GUARD_EN
        SCAN_GUARD: begin
          if (stop_i) begin
            state_q <= SCAN_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= SCAN_ACTIVE;
            g1_q    <= 1'b1;
            g2n_q   <= 1'b0;
          end
        end
`endif
        default: begin
          state_q <= SCAN_IDLE;
          g1_q    <= 1'b0;
          g2n_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign select_a_o = ch_q[0];
  assign select_b_o = ch_q[1];
  assign select_c_o = ch_q[2];
  assign g1_en_o    = g1_q;
  assign g2a_en_n_o = g2n_q;
  assign g2b_en_n_o = g2n_q;
  assign busy_o     = busy_q;
  assign wrap_o     = wrap_q;
  assign done_o     = done_q;
endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Bench for decoder_scan_ctrl: vector table, directed corner sequences and
// randomized scans compared against a per-scan expected output trace.
module tb_decoder_scan_ctrl;
`ifdef SCAN_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, start, stop, mode;
  logic [7:0] dwell, mask;
  logic       sa, sb, sc, g1, g2a, g2b, busy, wrap, done;
  logic [8:0] obs;

  int n_pass = 0;
  int n_tot  = 0;

  decoder_scan_ctrl #(.DWELL_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .mode_i(mode),
    .dwell_i(dwell), .skip_mask_i(mask),
    .select_a_o(sa), .select_b_o(sb), .select_c_o(sc),
    .g1_en_o(g1), .g2a_en_n_o(g2a), .g2b_en_n_o(g2b),
    .busy_o(busy), .wrap_o(wrap), .done_o(done)
  );

  always #5 clk = ~clk;

  assign obs = {sc, sb, sa, g1, g2a, g2b, busy, wrap, done};

  function automatic logic [8:0] mk(int sel, bit en, bit bz, bit wr, bit dn);
    logic [2:0] s;
    s = sel[2:0];
    return {s, en, ~en, ~en, bz, wr, dn};
  endfunction

  task automatic check(string nm, logic [8:0] got, logic [8:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", nm, got, exp);
  endtask

  task automatic check_int(string nm, int got, int exp);
    n_tot++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    bit         st, sp, md;
    logic [7:0] dw, mk;
    logic [8:0] exp;
  } vec_t;

  vec_t       tbl[12];
  logic [8:0] q[$];
  int         chans[$];
  logic [7:0] m;
  int         d, md_r, len, idx, nx, en_cnt, done_cnt, bad, k, wr_bad, found;
  bit         wr;
  logic [2:0] prev_sel;
  int         seq[4] = '{1, 3, 4, 6};

  initial begin
    rst = 1'b1; start = 0; stop = 0; mode = 0; dwell = 0; mask = 0;
    tick();
    tick();
    check("reset_state", obs, mk(0, 0, 0, 0, 0));
    rst = 1'b0;
    tick();

    // Vector table: same-cycle start/stop, masked start, single/continuous,
    // start while busy must not re-latch dwell or mode.
    tbl[0]  = '{1, 1, 0, 8'd0, 8'h00, mk(0, 0, 0, 0, 0)};
    tbl[1]  = '{1, 0, 0, 8'd0, 8'hFF, mk(0, 0, 0, 0, 0)};
    tbl[2]  = '{1, 0, 1, 8'd0, 8'h7F, mk(7, 1, 1, 0, 0)};
    tbl[3]  = '{0, 0, 0, 8'd0, 8'h7F, mk(7, 0, 0, 0, 1)};
    tbl[4]  = '{0, 0, 0, 8'd0, 8'h7F, mk(7, 0, 0, 0, 0)};
    tbl[5]  = '{1, 0, 0, 8'd3, 8'hFB, mk(2, 1, 1, 0, 0)};
    tbl[6]  = '{1, 0, 1, 8'd0, 8'hFB, mk(2, 1, 1, 0, 0)};
    tbl[7]  = '{0, 0, 0, 8'd0, 8'hFB, mk(2, 1, 1, 0, 0)};
    tbl[8]  = '{0, 0, 0, 8'd0, 8'hFB, mk(2, 1, 1, 0, 0)};
    tbl[9]  = '{0, 0, 0, 8'd0, 8'hFB, mk(2, !GUARD, 1, 1, 0)};
    tbl[10] = '{1, 1, 0, 8'd0, 8'hFB, mk(2, 0, 0, 0, 0)};
    tbl[11] = '{0, 0, 0, 8'd0, 8'hFB, mk(2, 0, 0, 0, 0)};
    for (int i = 0; i < 12; i++) begin
      start = tbl[i].st; stop = tbl[i].sp; mode = tbl[i].md;
      dwell = tbl[i].dw; mask = tbl[i].mk;
      tick();
      check($sformatf("tbl%0d", i), obs, tbl[i].exp);
    end
    start = 0; stop = 0;

    // Asynchronous reset while channel 5 is active.
    mode = 1; dwell = 8'd9; mask = 8'h1F; start = 1;
    tick();
    start = 0;
    check("ch5_active", obs, mk(5, 1, 1, 0, 0));
    tick();
    #2 rst = 1'b1;
    #1 check("rst_mid_scan", obs, mk(0, 0, 0, 0, 0));
    tick();
    rst = 1'b0;
    tick();

    // Single sweep, all channels, dwell 2.
    mode = 1; dwell = 8'd2; mask = 8'h00; start = 1;
    en_cnt = 0; done_cnt = 0; bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      start = 0;
      if (g1 && !g2a && !g2b) begin
        if (int'({sc, sb, sa}) != en_cnt / 3) bad++;
        en_cnt++;
      end
      if (done) done_cnt++;
    end
    check_int("sweep_enabled_cycles", en_cnt, 24);
    check_int("sweep_done_pulses", done_cnt, 1);
    check_int("sweep_order_errors", bad, 0);
    check("sweep_end_idle", obs, mk(7, 0, 0, 0, 0));

    // Continuous, mask 1010_0101, dwell 0: 1,3,4,6 repeating.
    mode = 0; dwell = 8'd0; mask = 8'hA5; start = 1;
    k = 0; bad = 0; wr_bad = 0; prev_sel = 3'd0;
    for (int i = 0; i < 20; i++) begin
      tick();
      start = 0;
      if (g1) begin
        if (int'({sc, sb, sa}) != seq[k % 4]) bad++;
        k++;
      end
      if (wrap !== (i > 0 && {sc, sb, sa} == 3'd1 && prev_sel != 3'd1)) wr_bad++;
      prev_sel = {sc, sb, sa};
    end
    check_int("cont_seq_errors", bad, 0);
    check_int("cont_wrap_errors", wr_bad, 0);
    stop = 1;
    tick();
    stop = 0;
    check("cont_stop", obs, {prev_sel, 6'b011000});

    // Stop during channel 2.
    mode = 1; dwell = 8'd3; mask = 8'h00; start = 1;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      start = 0;
      if ({sc, sb, sa} == 3'd2 && g1) found = 1;
    end
    check_int("reach_ch2", found, 1);
    stop = 1;
    tick();
    stop = 0;
    check("stop_ch2", obs, mk(2, 0, 0, 0, 0));
    tick();
    check("stop_ch2_no_done", obs, mk(2, 0, 0, 0, 0));

    // Mask goes all-ones during a continuous scan.
    mode = 0; dwell = 8'd1; mask = 8'h00; start = 1;
    tick();
    start = 0;
    check("ff_start", obs, mk(0, 1, 1, 0, 0));
    mask = 8'hFF;
    tick();
    check("ff_dwell", obs, mk(0, 1, 1, 0, 0));
    tick();
    check("ff_done", obs, mk(0, 0, 0, 0, 1));
    tick();
    check("ff_idle", obs, mk(0, 0, 0, 0, 0));

    // Randomized scans against an expected trace built from channel lists.
    for (int it = 0; it < 30; it++) begin
      m = 8'($urandom_range(0, 254));
      d = $urandom_range(0, 3);
      md_r = $urandom_range(0, 1);
      chans.delete();
      q.delete();
      for (int c = 0; c < 8; c++) if (!m[c]) chans.push_back(c);
      if (md_r == 1) begin
        for (int i = 0; i < chans.size(); i++) begin
          for (int j = 0; j <= d; j++) q.push_back(mk(chans[i], 1, 1, 0, 0));
          if (GUARD && i < chans.size() - 1) q.push_back(mk(chans[i + 1], 0, 1, 0, 0));
        end
        q.push_back(mk(chans[chans.size() - 1], 0, 0, 0, 1));
        q.push_back(mk(chans[chans.size() - 1], 0, 0, 0, 0));
        len = q.size();
      end else begin
        len = $urandom_range(3, 40);
        idx = 0; wr = 0;
        while (q.size() < len) begin
          for (int j = 0; j <= d; j++) q.push_back(mk(chans[idx], 1, 1, wr && j == 0 && !GUARD, 0));
          nx = (idx + 1) % chans.size();
          wr = (nx == 0);
          if (GUARD) q.push_back(mk(chans[nx], 0, 1, wr, 0));
          idx = nx;
        end
      end
      mask = m; mode = md_r[0]; dwell = 8'(d); start = 1;
      for (int i = 0; i < len; i++) begin
        tick();
        start = 0;
        check($sformatf("rand%0d_cyc%0d", it, i), obs, q[i]);
      end
      if (md_r == 0) begin
        stop = 1;
        tick();
        stop = 0;
        check($sformatf("rand%0d_stop", it), obs, {q[len - 1][8:6], 6'b011000});
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
